if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_if.sv | 10 +
 rtl/if_fetch.sv | 116 +++++++++++
 tb/tb_if_fetch.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_if.sv
// Byte-wide instruction memory bus between if_fetch (master) and memory (slave).
interface if_fetch_if;
  logic        mem_req_o;
  logic [31:0] mem_a_o;
  logic [7:0]  mem_din_i;
  logic        mem_ready_i;

  modport master (output mem_req_o, mem_a_o, input mem_din_i, mem_ready_i);
  modport slave  (input mem_req_o, mem_a_o, output mem_din_i, mem_ready_i);
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit words from a byte-wide memory and presents them to decode.
// Optional macro IF_ICACHE_EN adds a 16-entry direct-mapped instruction cache.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             branch_flag_i,
  input  logic [31:0]      branch_address_i,
  if_fetch_if.master       mem,
  output logic [31:0]      pc_o,
  output logic [31:0]      inst_o,
  output logic             inst_valid_o
);

  typedef enum logic {S_FETCH, S_VALID} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_cnt;
  logic [31:0] r_inst;
  logic        r_valid;

  logic        w_hit;
  logic [31:0] w_cache_word;
  logic        w_req;
  logic        w_unused_bits;

  assign w_unused_bits = ^branch_address_i[1:0];

`ifdef IF_ICACHE_EN
  logic [15:0] r_cval;
  logic [25:0] r_ctag  [16];
  logic [31:0] r_cdata [16];
  logic [3:0]  w_idx;
  logic        w_fill;

  assign w_idx        = r_pc[5:2];
  assign w_hit        = (r_state == S_FETCH) && (r_cnt == 2'd0) && r_cval[w_idx] &&
                        (r_ctag[w_idx] == r_pc[31:6]);
  assign w_cache_word = r_cdata[w_idx];
  // A redirect in the same cycle as the last byte abandons the fill, so nothing is written.
  assign w_fill       = w_req && mem.mem_ready_i && (r_cnt == 2'd3) && !branch_flag_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cval <= '0;
    end else if (w_fill) begin
      r_cval[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_ctag[w_idx]  <= r_pc[31:6];
      r_cdata[w_idx] <= {mem.mem_din_i, r_inst[23:0]};
    end
  end
`else
  assign w_hit        = 1'b0;
  assign w_cache_word = '0;
`endif

  // Request is gated by rst_n so it drops the moment reset asserts.
  assign w_req           = rst_n && (r_state == S_FETCH) && !w_hit;
  assign mem.mem_req_o   = w_req;
  assign mem.mem_a_o     = w_req ? (r_pc + {30'd0, r_cnt}) : '0;

  assign pc_o         = r_pc;
  assign inst_o       = r_inst;
  assign inst_valid_o = r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_cnt   <= '0;
      r_inst  <= '0;
      r_valid <= 1'b0;
    end else if (branch_flag_i) begin
      r_state <= S_FETCH;
      r_pc    <= {branch_address_i[31:2], 2'b00};
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (w_hit) begin
            r_inst  <= w_cache_word;
            r_state <= S_VALID;
            r_valid <= 1'b1;
          end else if (mem.mem_ready_i) begin
            r_inst[{r_cnt, 3'b000} +: 8] <= mem.mem_din_i;
            if (r_cnt == 2'd3) begin
              r_cnt   <= '0;
              r_state <= S_VALID;
              r_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 2'd1;
            end
          end
        end
        S_VALID: begin
          if (!stall_i) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_FETCH;
            r_valid <= 1'b0;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset, stall, branch, wrap, ready throttling and reset mid-fetch.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        br;
  logic [31:0] ba;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid;
  logic [7:0]  mem [512];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall_i          (stall),
    .branch_flag_i    (br),
    .branch_address_i (ba),
    .mem              (bus),
    .pc_o             (pc),
    .inst_o           (inst),
    .inst_valid_o     (valid)
  );

  always #5 clk = ~clk;

  assign bus.mem_din_i = mem[bus.mem_a_o[8:0]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    stall = 1'b1;
    br    = 1'b0;
    ba    = '0;
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0]     = 8'h13; mem[1]     = 8'h05; mem[2]     = 8'h10; mem[3]     = 8'h00;
    mem[4]     = 8'h93; mem[5]     = 8'h00; mem[6]     = 8'h10; mem[7]     = 8'h00;
    mem[9'h100] = 8'h33; mem[9'h101] = 8'h81; mem[9'h102] = 8'h20; mem[9'h103] = 8'h00;
    mem[9'h1FC] = 8'h6f;

    @(negedge clk);
    @(negedge clk);
    check_val("rst_valid", {31'd0, valid}, 32'd0);
    check_val("rst_req",   {31'd0, bus.mem_req_o}, 32'd0);
    check_val("rst_addr",  bus.mem_a_o, 32'd0);
    check_val("rst_pc",    pc, 32'd0);
    check_val("rst_inst",  inst, 32'd0);

    rst_n = 1'b1;
    #1;
    check_val("first_req",  {31'd0, bus.mem_req_o}, 32'd1);
    check_val("first_addr", bus.mem_a_o, 32'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      check_val("fetch_addr", bus.mem_a_o, k);
      step(1);
    end
    check_val("c5_valid", {31'd0, valid}, 32'd1);
    check_val("c5_inst",  inst, 32'h0010_0513);
    check_val("c5_pc",    pc, 32'd0);
    check_val("c5_req",   {31'd0, bus.mem_req_o}, 32'd0);
    check_val("c5_addr",  bus.mem_a_o, 32'd0);

    for (int unsigned k = 0; k < 3; k++) begin
      step(1);
      check_val("stall_inst",  inst, 32'h0010_0513);
      check_val("stall_valid", {31'd0, valid}, 32'd1);
      check_val("stall_req",   {31'd0, bus.mem_req_o}, 32'd0);
    end
    stall = 1'b0;
    step(1);
    stall = 1'b1;
    check_val("consume_valid", {31'd0, valid}, 32'd0);
    check_val("consume_addr",  bus.mem_a_o, 32'd4);
    step(4);
    check_val("w1_valid", {31'd0, valid}, 32'd1);
    check_val("w1_inst",  inst, 32'h0010_0093);
    check_val("w1_pc",    pc, 32'd4);

    // Redirect while the third byte is outstanding.
    stall = 1'b0;
    step(1);
    stall = 1'b1;
    step(2);
    check_val("cnt2_addr", bus.mem_a_o, 32'h0000_000A);
    br = 1'b1;
    ba = 32'h0000_0102;
    step(1);
    br = 1'b0;
    check_val("br_addr",  bus.mem_a_o, 32'h0000_0100);
    check_val("br_valid", {31'd0, valid}, 32'd0);
    step(4);
    check_val("br_inst", inst, 32'h0020_8133);
    check_val("br_pc",   pc, 32'h0000_0100);

    // Branch wins over stall; then wrap from the top of the address space.
    ba = 32'hFFFF_FFFE;
    br = 1'b1;
    step(1);
    br = 1'b0;
    check_val("brst_valid", {31'd0, valid}, 32'd0);
    check_val("brst_addr",  bus.mem_a_o, 32'hFFFF_FFFC);
    step(4);
    check_val("top_valid", {31'd0, valid}, 32'd1);
    check_val("top_inst",  inst, 32'h0000_006f);
    check_val("top_pc",    pc, 32'hFFFF_FFFC);
    stall = 1'b0;
    step(1);
    stall = 1'b1;
    check_val("wrap_addr", bus.mem_a_o, 32'd0);
    check_val("wrap_req",  {31'd0, bus.mem_req_o}, 32'd1);

    for (int unsigned i = 0; i < 7; i++) begin
      bus.mem_ready_i = (i % 2 == 0);
      check_val("tgl_addr",  bus.mem_a_o, (i + 1) / 2);
      check_val("tgl_valid", {31'd0, valid}, 32'd0);
      step(1);
    end
    bus.mem_ready_i = 1'b1;
    check_val("tgl_done_valid", {31'd0, valid}, 32'd1);
    check_val("tgl_done_inst",  inst, 32'h0010_0513);

    // Reset asserted with two bytes of the next word captured.
    stall = 1'b0;
    step(1);
    stall = 1'b1;
    step(2);
    check_val("mid_addr", bus.mem_a_o, 32'd6);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'd0, valid}, 32'd0);
    check_val("mid_rst_req",   {31'd0, bus.mem_req_o}, 32'd0);
    check_val("mid_rst_addr",  bus.mem_a_o, 32'd0);
    check_val("mid_rst_pc",    pc, 32'd0);
    check_val("mid_rst_inst",  inst, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("restart_req",  {31'd0, bus.mem_req_o}, 32'd1);
    check_val("restart_addr", bus.mem_a_o, 32'd0);
    step(4);
    check_val("restart_valid", {31'd0, valid}, 32'd1);
    check_val("restart_inst",  inst, 32'h0010_0513);

    br = 1'b1;
    ba = 32'd0;
    step(1);
    br = 1'b0;
`ifdef IF_ICACHE_EN
    check_val("hit_req", {31'd0, bus.mem_req_o}, 32'd0);
    step(1);
`else
    check_val("loop_req",  {31'd0, bus.mem_req_o}, 32'd1);
    check_val("loop_addr", bus.mem_a_o, 32'd0);
    step(4);
`endif
    check_val("loop_valid", {31'd0, valid}, 32'd1);
    check_val("loop_inst",  inst, 32'h0010_0513);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
